tone_key_scheduler: RTL and testbench
=====================================

Name: tone_key_scheduler

Overview:
- Arbitrates up to NUM_KEYS synthesizer key requests onto one shared programmable tone divider.
- Selects the winning key and programs its half-period from a note table.
- Inserts a silent gap on note change and gates the square-wave output.
- Sits between the debounced keyboard inputs and the audio output pin; replaces per-note fixed timers with one sequenced divider.

Parameters:
- NUM_KEYS, 8, number of key requesters (max 8); index 0 = C4 … index 7 = C5.
- HP_W, 17, width of half-period values and of the divider counter.
- GAP_CYCLES, 250000, silent cycles inserted on note change (5 ms at 50 MHz); must be ≥1.
- SUSTAIN_CYCLES, 1000000, hold time after key release; used only with SUSTAIN_EN.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  synchronous enable; low forces IDLE.
- key_in  in  NUM_KEYS  key requests; synchronous to clk, debounced upstream.
- tone_out  out  1  square-wave audio output.
- playing  out  1  high while in PLAY.
- active_key  out  3  index of the key currently sounding; 0 when not playing.
- busy  out  1  high in PLAY, GAP or SUSTAIN.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; divider counter=0.
  - tone_out=0, playing=0, active_key=0, busy=0, all immediately.
  - Mid-note reset truncates the note with no glitch beyond the forced 0.
- Arbitration:
  - Fixed priority; the highest asserted index wins.
  - Winner is computed combinationally each cycle from key_in & {NUM_KEYS{enable}}.
- Half-period lookup: HP[i] from package table NOTE_HP, in order 95555, 85131, 75843, 71586, 63776, 56818, 50619, 47778.
- Divider:
  - Counts 0..HP-1. When the count equals HP-1, it wraps to 0 and tone_out toggles.
  - Each tone_out level therefore lasts exactly HP cycles.
  - On load, the counter clears to 0 and tone_out clears to 0.
  - The divider runs only in PLAY; in every other state it is held cleared and tone_out=0.
- IDLE:
  - Any winner sampled at edge k → state=PLAY, active_key=winner, divider loaded, all after edge k.
  - playing=1 from edge k. First tone_out rise occurs after edge k+HP.
- PLAY:
  - If the winner equals active_key, stay in PLAY.
  - If the winner differs and is non-empty → GAP; gap counter=0; tone_out=0 next cycle.
  - If no key is asserted → IDLE (or SUSTAIN; see Optional Feature).
  - If enable=0 → IDLE next edge, from any state.
- GAP:
  - Counts GAP_CYCLES cycles.
  - On the final cycle, the winner is re-evaluated: non-empty → PLAY with a fresh load; empty → IDLE.
  - Key changes during the gap are ignored until the final cycle.
  - playing=0 and busy=1 throughout.
- Simultaneous events: when a key press and a key release land in the same cycle, only the resulting winner is used; no intermediate note is sounded.
- Width rules:
  - All HP values are < 2^HP_W; the counter never exceeds HP-1.
  - The gap counter width is $clog2(GAP_CYCLES+1) and saturates at terminal count.

Optional Feature:
- Macro: TONE_SUSTAIN_EN.
- Defined:
  - PLAY with no key asserted → SUSTAIN. The divider keeps running on the same note for SUSTAIN_CYCLES, with playing=0 and busy=1.
  - After SUSTAIN_CYCLES → IDLE.
  - Same key re-pressed during SUSTAIN → PLAY without reload (phase continuous).
  - Different key pressed during SUSTAIN → GAP.
- Undefined: the SUSTAIN state does not exist; key release goes directly to IDLE next edge.

Decomposition:
- Package synth_pkg holds:
  - NOTE_HP table.
  - HP_W default.
  - State encoding: IDLE=0, PLAY=1, GAP=2, SUSTAIN=3.
  - CLK_HZ=50_000_000.
- One sub-module: tone_divider, with ports clk, reset, run, load, half_period[HP_W-1:0], tone_out.
- The scheduler FSM, arbiter and gap/sustain counters stay in the top module.

Test Plan:
- Reset, then press key 7 (C5) → after 1 cycle playing=1, active_key=7; tone_out rises after 47778 cycles and has a period of 95556 cycles.
- Hold key 0 and key 5 together → active_key=5; measured half-period is 56818 cycles.
- GAP_CYCLES=16: playing key 2, switch to key 4 → tone_out=0 for 16 cycles, then a fresh load with active_key=4; first rise 63776 cycles after the load edge.
- GAP_CYCLES=16: release all keys during the gap → IDLE at gap end; busy=0; tone_out stays 0.
- Drive reset low mid-note with tone_out=1 → tone_out=0 and state=IDLE with no clock edge; releasing reset with key 3 held → PLAY next edge.
- With TONE_SUSTAIN_EN and SUSTAIN_CYCLES=100: release key 1, re-press it after 50 cycles → no reload and tone_out phase continues. Without re-press → IDLE after 100 cycles.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared synthesizer definitions: note half-period table, default divider width,
// scheduler state encoding and the system clock rate.
package synth_pkg;

  localparam int HP_W   = 17;
  localparam int CLK_HZ = 50_000_000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAY    = 2'd1,
    GAP     = 2'd2,
    SUSTAIN = 2'd3
  } state_t;

  // Index 0 is C4, index 7 is C5; entry [i] is the half-period in clk cycles.
  localparam logic [7:0][16:0] NOTE_HP = {
    17'd47778, 17'd50619, 17'd56818, 17'd63776,
    17'd71586, 17'd75843, 17'd85131, 17'd95555
  };

endpackage

// File: rtl/tone_divider.sv
// Programmable square-wave divider: each tone_out level lasts half_period cycles.
// Held cleared (count 0, tone_out 0) whenever run is low or load is high.
module tone_divider #(
  parameter int HP_W = 17
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            load,
  input  logic [HP_W-1:0] half_period,
  output logic            tone_out
);

  logic [HP_W-1:0] count;
  logic [HP_W-1:0] hp_last;

  assign hp_last = half_period - HP_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      tone_out <= 1'b0;
    end else if (load || !run) begin
      count    <= '0;
      tone_out <= 1'b0;
    end else if (count == hp_last) begin
      count    <= '0;
      tone_out <= ~tone_out;
    end else begin
      count    <= count + HP_W'(1);
    end
  end

endmodule

// File: rtl/tone_key_scheduler.sv
// Fixed-priority key arbiter and note sequencer driving one shared tone divider.
// Define TONE_SUSTAIN_EN to add the SUSTAIN state and the SUSTAIN_CYCLES parameter.
module tone_key_scheduler #(
  parameter int NUM_KEYS   = 8,
  parameter int HP_W       = synth_pkg::HP_W,
  parameter int GAP_CYCLES = 250000
`ifdef TONE_SUSTAIN_EN
  , parameter int SUSTAIN_CYCLES = 1000000
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic                tone_out,
  output logic                playing,
  output logic [2:0]          active_key,
  output logic                busy
);

  import synth_pkg::*;

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [GW-1:0] GAP_TERM = GW'(GAP_CYCLES);
`ifdef TONE_SUSTAIN_EN
  localparam int SW = $clog2(SUSTAIN_CYCLES + 1);
  localparam logic [SW-1:0] SUS_LAST = SW'(SUSTAIN_CYCLES - 1);
`endif

  state_t              state, state_nx;
  logic [2:0]          cur_key, key_nx;
  logic [GW-1:0]       gap_cnt, gap_nx;
`ifdef TONE_SUSTAIN_EN
  logic [SW-1:0]       sus_cnt, sus_nx;
`endif
  logic [NUM_KEYS-1:0] masked;
  logic [2:0]          win;
  logic                any_key;
  logic                load;
  logic                run;

  // Highest asserted index wins; enable low looks like no key at all.
  always_comb begin
    masked  = key_in & {NUM_KEYS{enable}};
    win     = 3'd0;
    any_key = |masked;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (masked[i]) win = 3'(i);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cur_key <= 3'd0;
      gap_cnt <= '0;
`ifdef TONE_SUSTAIN_EN
      sus_cnt <= '0;
`endif
    end else begin
      state   <= state_nx;
      cur_key <= key_nx;
      gap_cnt <= gap_nx;
`ifdef TONE_SUSTAIN_EN
      sus_cnt <= sus_nx;
`endif
    end
  end

  always_comb begin
    state_nx = state;
    key_nx   = cur_key;
    gap_nx   = '0;
`ifdef TONE_SUSTAIN_EN
    sus_nx   = '0;
`endif
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (any_key) begin
          state_nx = PLAY;
          key_nx   = win;
          load     = 1'b1;
        end
      end
      PLAY: begin
        if (!any_key) begin
`ifdef TONE_SUSTAIN_EN
          state_nx = SUSTAIN;
`else
          state_nx = IDLE;
`endif
        end else if (win != cur_key) begin
          state_nx = GAP;
        end
      end
      GAP: begin
        // Keys are only looked at again on the last gap cycle.
        if (gap_cnt == GAP_LAST) begin
          if (any_key) begin
            state_nx = PLAY;
            key_nx   = win;
            load     = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          gap_nx = (gap_cnt == GAP_TERM) ? gap_cnt : gap_cnt + GW'(1);
        end
      end
`ifdef TONE_SUSTAIN_EN
      SUSTAIN: begin
        if (any_key) begin
          state_nx = (win == cur_key) ? PLAY : GAP;
        end else if (sus_cnt == SUS_LAST) begin
          state_nx = IDLE;
        end else begin
          sus_nx = sus_cnt + SW'(1);
        end
      end
`endif
      default: state_nx = IDLE;
    endcase
    if (!enable) begin
      state_nx = IDLE;
      load     = 1'b0;
    end
  end

  // The divider runs only while the next state keeps the note sounding.
  assign run = (state_nx == PLAY) || (state_nx == SUSTAIN);

  tone_divider #(
    .HP_W(HP_W)
  ) u_div (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .load       (load),
    .half_period(HP_W'(NOTE_HP[cur_key])),
    .tone_out   (tone_out)
  );

  assign playing    = (state == PLAY);
  assign busy       = (state != IDLE);
  assign active_key = playing ? cur_key : 3'd0;

endmodule

// File: tb/tb_tone_key_scheduler.sv
// Scoreboard bench for tone_key_scheduler (default build, GAP_CYCLES=16):
// a note-level reference model queues expected outputs, a monitor compares each cycle.
module tb_tone_key_scheduler;

  localparam int GAP = 16;

  logic       clk    = 1'b0;
  logic       reset  = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] key_in = '0;
  logic       tone_out, playing, busy;
  logic [2:0] active_key;

  int vectors     = 0;
  int miscompares = 0;

  logic [5:0] exp_q[$];
  int hp_tab[8] = '{95555, 85131, 75843, 71586, 63776, 56818, 50619, 47778};

  // Model: mode 0 silent, 1 sounding, 2 gap; m_t counts edges since the note load.
  int m_mode = 0;
  int m_key  = 0;
  int m_t    = 0;
  int m_gap_left = 0;

  always #5 clk = ~clk;

  tone_key_scheduler #(
    .NUM_KEYS  (8),
    .HP_W      (17),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .key_in    (key_in),
    .tone_out  (tone_out),
    .playing   (playing),
    .active_key(active_key),
    .busy      (busy)
  );

  function automatic int top_key(input logic [7:0] k, input logic en);
    int w = -1;
    if (en) for (int i = 0; i < 8; i++) if (k[i]) w = i;
    return w;
  endfunction

  task automatic model_step(input logic [7:0] k, input logic en);
    int w = top_key(k, en);
    if (!en) m_mode = 0;
    else if (m_mode == 0) begin
      if (w >= 0) begin m_mode = 1; m_key = w; m_t = 0; end
    end else if (m_mode == 1) begin
      m_t++;
      if (w < 0) m_mode = 0;
      else if (w != m_key) begin m_mode = 2; m_gap_left = GAP; end
    end else begin
      m_gap_left--;
      if (m_gap_left == 0) begin
        if (w >= 0) begin m_mode = 1; m_key = w; m_t = 0; end
        else m_mode = 0;
      end
    end
  endtask

  function automatic logic [5:0] model_out();
    logic t;
    t = (m_mode == 1) && (((m_t / hp_tab[m_key]) % 2) == 1);
    return {t, m_mode == 1, m_mode != 0, (m_mode == 1) ? 3'(m_key) : 3'd0};
  endfunction

  task automatic check_output(input string name, input logic [5:0] exp);
    logic [5:0] got;
    got = {tone_out, playing, busy, active_key};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s t=%0t got tone=%b play=%b busy=%b key=%0d expected tone=%b play=%b busy=%b key=%0d",
               name, $time, got[5], got[4], got[3], got[2:0], exp[5], exp[4], exp[3], exp[2:0]);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] k, input logic en);
    key_in = k;
    enable = en;
    model_step(k, en);
    exp_q.push_back(model_out());
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) check_output("cycle", exp_q.pop_front());
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog expired at t=%0t", $time);
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] k;
    #12;
    check_output("reset_state", model_out());
    @(posedge clk);
    #2;
    reset = 1'b1;
    repeat (3) apply_stimulus(8'h00, 1'b1);

    // C5 held long enough to pass its first rising edge.
    repeat (47778 + 4) apply_stimulus(8'h80, 1'b1);
    check_output("pre_reset_tone_high", model_out());

    reset = 1'b0;
    #1;
    m_mode = 0;
    check_output("async_reset", model_out());
    key_in = 8'h08;
    #1;
    reset = 1'b1;
    repeat (4) apply_stimulus(8'h08, 1'b1);

    repeat (24) apply_stimulus(8'h21, 1'b1);
    repeat (2)  apply_stimulus(8'h00, 1'b1);
    repeat (4)  apply_stimulus(8'h04, 1'b1);
    repeat (22) apply_stimulus(8'h10, 1'b1);
    repeat (3)  apply_stimulus(8'h04, 1'b1);
    repeat (20) apply_stimulus(8'h00, 1'b1);
    repeat (4)  apply_stimulus(8'h40, 1'b1);
    repeat (3)  apply_stimulus(8'h80, 1'b0);

    k = 8'h00;
    repeat (3000) begin
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 2))
          0:       k = 8'h00;
          1:       k = 8'(1 << $urandom_range(0, 7));
          default: k = 8'($urandom);
        endcase
      end
      apply_stimulus(k, $urandom_range(0, 39) != 0);
    end
    repeat (2) apply_stimulus(8'h00, 1'b1);

    @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain left=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
